// File: rtl/control_unit.sv
// Multi-cycle control unit: two-byte instruction fetch, decode, one or two
// execute cycles, and a sticky HALT. The datapath controls are decoded
// combinationally from the current state and the opcode fields latched in DECODE.
module control_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] IROut,
  input  logic        z_flag,
  output logic [3:0]  RegSel_rf,
  output logic [3:0]  ScrSel,
  output logic [2:0]  FunSel3,
  output logic [2:0]  OutASel,
  output logic [2:0]  OutBSel,
  output logic        MuxDSel,
  output logic [4:0]  FunSel5,
  output logic [1:0]  MuxCSel,
  output logic        LH,
  output logic        write,
  output logic        E,
  output logic [1:0]  FunSel2_dr,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic [2:0]  RegSel_arf,
  output logic [1:0]  FunSel2_arf,
  output logic [1:0]  OutCSel,
  output logic [1:0]  OutDSel,
  output logic        mem_cs,
  output logic        mem_wr,
  output logic        halted,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    StFetchL = 3'd0,
    StFetchH = 3'd1,
    StDecode = 3'd2,
    StExec1  = 3'd3,
    StExec2  = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [3:0] OpLdi = 4'h8;
  localparam logic [3:0] OpLd  = 4'h9;
  localparam logic [3:0] OpBra = 4'hA;
  localparam logic [3:0] OpBrz = 4'hB;
  localparam logic [3:0] OpHlt = 4'hF;

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [1:0] dst_q, dst_d;
  logic [2:0] sa_q, sa_d;
  logic [2:0] sb_q, sb_d;

  // IR bits 9 and 2:0 carry no meaning for this instruction set.
  logic unused_ir;
  assign unused_ir = ^{IROut[9], IROut[2:0]};

  // Next-state and field-latch logic.
  always_comb begin
    state_d = StFetchL;
    op_d    = op_q;
    dst_d   = dst_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    case (state_q)
      StFetchL: state_d = StFetchH;
      StFetchH: state_d = StDecode;
      StDecode: begin
        op_d  = IROut[15:12];
        dst_d = IROut[11:10];
        sa_d  = IROut[8:6];
        sb_d  = IROut[5:3];
        if (IROut[15:12] == OpHlt)     state_d = StHalt;
        else if (IROut[15:12] >= 4'hC) state_d = StFetchL;  // NOP range
        else                           state_d = StExec1;
      end
      StExec1:  state_d = (op_q == OpLd) ? StExec2 : StFetchL;
      StExec2:  state_d = StFetchL;
      StHalt:   state_d = StHalt;
      default:  state_d = StFetchL;  // unused encodings recover to fetch
    endcase
  end

  // State and latched instruction fields; reset aborts any instruction in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StFetchL;
      op_q    <= 4'h0;
      dst_q   <= 2'b00;
      sa_q    <= 3'b000;
      sb_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
    end
  end

  // Datapath control decode from state and latched fields.
  always_comb begin
    RegSel_rf   = 4'b0000;
    ScrSel      = 4'b0000;
    FunSel3     = 3'b000;
    OutASel     = 3'b000;
    OutBSel     = 3'b000;
    MuxDSel     = 1'b0;
    FunSel5     = 5'b00000;
    MuxCSel     = 2'b00;
    LH          = 1'b0;
    write       = 1'b0;
    E           = 1'b0;
    FunSel2_dr  = 2'b00;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    RegSel_arf  = 3'b000;
    FunSel2_arf = 2'b00;
    OutCSel     = 2'b00;
    OutDSel     = 2'b00;
    mem_cs      = 1'b0;
    mem_wr      = 1'b0;
    halted      = 1'b0;
    case (state_q)
      StFetchL, StFetchH: begin
        // Read memory at PC into one IR half, then increment PC.
        OutDSel     = 2'b00;
        mem_cs      = 1'b1;
        write       = 1'b1;
        LH          = (state_q == StFetchH);
        RegSel_arf  = 3'b100;
        FunSel2_arf = 2'b01;
      end
      StExec1: begin
        if (op_q[3] == 1'b0) begin
          OutASel   = sa_q;
          OutBSel   = sb_q;
          MuxDSel   = 1'b0;
          FunSel5   = {2'b10, op_q[2:0]};
          MuxASel   = 2'b00;
          RegSel_rf = 4'b1000 >> dst_q;
          FunSel3   = 3'b010;
        end else if (op_q == OpLdi) begin
          MuxASel   = 2'b11;
          RegSel_rf = 4'b1000 >> dst_q;
          FunSel3   = 3'b010;
        end else if (op_q == OpLd) begin
          // Memory at AR into DR; register write follows in EXEC2.
          OutDSel    = 2'b01;
          mem_cs     = 1'b1;
          E          = 1'b1;
          FunSel2_dr = 2'b01;
        end else if (op_q == OpBra || (op_q == OpBrz && z_flag)) begin
          MuxBSel     = 2'b11;
          RegSel_arf  = 3'b100;
          FunSel2_arf = 2'b10;
        end
      end
      StExec2: begin
        if (op_q == OpLd) begin
          MuxASel   = 2'b10;
          RegSel_rf = 4'b1000 >> dst_q;
          FunSel3   = 3'b010;
        end
      end
      StHalt:  halted = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: table of instruction vectors with per-cycle expected
// outputs fed through a scoreboard queue, plus reset-abort and HALT sequences.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ir    = 16'h0000;
  logic        z     = 1'b0;

  logic [3:0] RegSel_rf, ScrSel;
  logic [2:0] FunSel3, OutASel, OutBSel, RegSel_arf, state;
  logic       MuxDSel, LH, write, E, mem_cs, mem_wr, halted;
  logic [4:0] FunSel5;
  logic [1:0] MuxCSel, FunSel2_dr, MuxASel, MuxBSel, FunSel2_arf, OutCSel, OutDSel;

  control_unit dut (
    .clock(clock), .reset(reset), .IROut(ir), .z_flag(z),
    .RegSel_rf(RegSel_rf), .ScrSel(ScrSel), .FunSel3(FunSel3),
    .OutASel(OutASel), .OutBSel(OutBSel), .MuxDSel(MuxDSel), .FunSel5(FunSel5),
    .MuxCSel(MuxCSel), .LH(LH), .write(write), .E(E), .FunSel2_dr(FunSel2_dr),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .RegSel_arf(RegSel_arf),
    .FunSel2_arf(FunSel2_arf), .OutCSel(OutCSel), .OutDSel(OutDSel),
    .mem_cs(mem_cs), .mem_wr(mem_wr), .halted(halted), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] regsel_rf;
    logic [3:0] scrsel;
    logic [2:0] funsel3;
    logic [2:0] outasel;
    logic [2:0] outbsel;
    logic       muxdsel;
    logic [4:0] funsel5;
    logic [1:0] muxcsel;
    logic       lh;
    logic       write;
    logic       e;
    logic [1:0] funsel2_dr;
    logic [1:0] muxasel;
    logic [1:0] muxbsel;
    logic [2:0] regsel_arf;
    logic [1:0] funsel2_arf;
    logic [1:0] outcsel;
    logic [1:0] outdsel;
    logic       mem_cs;
    logic       mem_wr;
    logic       halted;
    logic [2:0] state;
  } outs_t;

  typedef struct {
    logic [15:0] ir;
    logic        z;
    int          len;
    outs_t       exp [6];
  } vec_t;

  int    n_checks = 0;
  int    n_fails  = 0;
  outs_t sb_q[$];
  vec_t  vecs[10];

  function automatic outs_t idle(logic [2:0] st);
    outs_t o;
    o = '0;
    o.state = st;
    return o;
  endfunction

  function automatic outs_t fetch(logic lh);
    outs_t o;
    o = idle({2'b00, lh});
    o.mem_cs      = 1'b1;
    o.write       = 1'b1;
    o.lh          = lh;
    o.regsel_arf  = 3'b100;
    o.funsel2_arf = 2'b01;
    return o;
  endfunction

  function automatic outs_t halt_outs();
    outs_t o;
    o = idle(3'd5);
    o.halted = 1'b1;
    return o;
  endfunction

  // Common prefix FETCH_L, FETCH_H, DECODE and a closing FETCH_L.
  function automatic vec_t base(logic [15:0] i, logic zf, int len);
    vec_t v;
    v.ir  = i;
    v.z   = zf;
    v.len = len;
    for (int k = 0; k < 6; k++) v.exp[k] = '0;
    v.exp[0]     = fetch(1'b0);
    v.exp[1]     = fetch(1'b1);
    v.exp[2]     = idle(3'd2);
    v.exp[len-1] = fetch(1'b0);
    return v;
  endfunction

  function automatic outs_t act();
    outs_t o;
    o.regsel_rf = RegSel_rf;   o.scrsel = ScrSel;         o.funsel3 = FunSel3;
    o.outasel = OutASel;       o.outbsel = OutBSel;       o.muxdsel = MuxDSel;
    o.funsel5 = FunSel5;       o.muxcsel = MuxCSel;       o.lh = LH;
    o.write = write;           o.e = E;                   o.funsel2_dr = FunSel2_dr;
    o.muxasel = MuxASel;       o.muxbsel = MuxBSel;       o.regsel_arf = RegSel_arf;
    o.funsel2_arf = FunSel2_arf; o.outcsel = OutCSel;     o.outdsel = OutDSel;
    o.mem_cs = mem_cs;         o.mem_wr = mem_wr;         o.halted = halted;
    o.state = state;
    return o;
  endfunction

  // Pop one expected record and compare with the live outputs.
  task automatic check(string tag);
    outs_t e, a;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fails++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      a = act();
      if (a !== e) begin
        n_fails++;
        $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                 tag, a, a.state, e, e.state);
      end
    end
  endtask

  task automatic expect_now(outs_t e, string tag);
    sb_q.push_back(e);
    check(tag);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_vec(int idx, int upto);
    do_reset();
    ir = vecs[idx].ir;
    z  = vecs[idx].z;
    for (int c = 0; c < upto; c++) begin
      expect_now(vecs[idx].exp[c], $sformatf("vec%0d ir=%h cyc%0d", idx, vecs[idx].ir, c));
      if (c < upto - 1) begin
        @(posedge clock);
        @(negedge clock);
      end
    end
  endtask

  initial begin
    // LDI R1,0x05
    vecs[0] = base(16'h8105, 1'b0, 5);
    vecs[0].exp[3] = idle(3'd3);
    vecs[0].exp[3].regsel_rf = 4'b1000;
    vecs[0].exp[3].muxasel   = 2'b11;
    vecs[0].exp[3].funsel3   = 3'b010;
    // ALU op0, R1 <- R(sa=1) op R(sb=2)
    vecs[1] = base(16'h0250, 1'b0, 5);
    vecs[1].exp[3] = idle(3'd3);
    vecs[1].exp[3].outasel   = 3'b001;
    vecs[1].exp[3].outbsel   = 3'b010;
    vecs[1].exp[3].funsel5   = 5'b10000;
    vecs[1].exp[3].regsel_rf = 4'b1000;
    vecs[1].exp[3].funsel3   = 3'b010;
    // ALU op7 to R4, sa=7, sb=5
    vecs[2] = base(16'h7DEF, 1'b1, 5);
    vecs[2].exp[3] = idle(3'd3);
    vecs[2].exp[3].outasel   = 3'b111;
    vecs[2].exp[3].outbsel   = 3'b101;
    vecs[2].exp[3].funsel5   = 5'b10111;
    vecs[2].exp[3].regsel_rf = 4'b0001;
    vecs[2].exp[3].funsel3   = 3'b010;
    // BRZ not taken
    vecs[3] = base(16'hB0F0, 1'b0, 5);
    vecs[3].exp[3] = idle(3'd3);
    // BRZ taken
    vecs[4] = base(16'hB0F0, 1'b1, 5);
    vecs[4].exp[3] = idle(3'd3);
    vecs[4].exp[3].muxbsel     = 2'b11;
    vecs[4].exp[3].regsel_arf  = 3'b100;
    vecs[4].exp[3].funsel2_arf = 2'b10;
    // BRA ignores z_flag
    vecs[5] = base(16'hA0F0, 1'b0, 5);
    vecs[5].exp[3] = vecs[4].exp[3];
    // LD to R2
    vecs[6] = base(16'h9400, 1'b0, 6);
    vecs[6].exp[3] = idle(3'd3);
    vecs[6].exp[3].outdsel    = 2'b01;
    vecs[6].exp[3].mem_cs     = 1'b1;
    vecs[6].exp[3].e          = 1'b1;
    vecs[6].exp[3].funsel2_dr = 2'b01;
    vecs[6].exp[4] = idle(3'd4);
    vecs[6].exp[4].muxasel   = 2'b10;
    vecs[6].exp[4].regsel_rf = 4'b0100;
    vecs[6].exp[4].funsel3   = 3'b010;
    // NOPs go straight back to fetch
    vecs[7] = base(16'hC000, 1'b1, 4);
    vecs[8] = base(16'hE123, 1'b0, 4);
    // LDI R3
    vecs[9] = base(16'h8A00, 1'b0, 5);
    vecs[9].exp[3] = idle(3'd3);
    vecs[9].exp[3].regsel_rf = 4'b0010;
    vecs[9].exp[3].muxasel   = 2'b11;
    vecs[9].exp[3].funsel3   = 3'b010;

    // Outputs under reset before any clock edge.
    #1;
    expect_now(fetch(1'b0), "reset state");

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i].len);

    // LD aborted by reset during EXEC1: EXEC2 must never appear.
    run_vec(6, 4);
    #2 reset = 1'b1;
    #1 expect_now(fetch(1'b0), "async reset mid-LD");
    @(posedge clock);
    @(negedge clock);
    expect_now(fetch(1'b0), "held in reset");
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    expect_now(fetch(1'b1), "after abort FETCH_H not EXEC2");

    // HALT holds for 20 cycles, then reset releases it.
    do_reset();
    ir = 16'hF000;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      @(negedge clock);
    end
    for (int c = 0; c < 20; c++) begin
      expect_now(halt_outs(), $sformatf("halt cyc%0d", c));
      @(posedge clock);
      @(negedge clock);
    end
    reset = 1'b1;
    #1 expect_now(fetch(1'b0), "reset out of halt");
    @(negedge clock);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
